// File: rtl/bcd_cascade_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_cascade_counter : prescaled up/down BCD counter with clamped load
// Rev 1.0
// ---------------------------------------------------------------------------
module bcd_cascade_counter #(
  parameter int NDIG    = 4,
  parameter int DIV     = 50000000,
  parameter int TOP_MOD = 10
) (
  input  logic              mclk,
  input  logic              reset,
  input  logic              en,
  input  logic              up,
  input  logic              load,
  input  logic [4*NDIG-1:0] load_val,
  output logic [4*NDIG-1:0] cnt,
  output logic              tick,
  output logic              wrap
);

  localparam int             c_PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [c_PW-1:0] c_PRE_LAST = c_PW'(DIV - 1);

  logic [c_PW-1:0]   r_pre;
  logic [4*NDIG-1:0] r_cnt;
  logic              r_wrap;

  logic [NDIG:0]     w_lo_max;
  logic [NDIG:0]     w_lo_zero;
  logic [4*NDIG-1:0] w_step_val;
  logic [4*NDIG-1:0] w_load_val;
  logic              w_tick;
  logic              w_full;

  assign w_tick       = en && !reset && (r_pre == c_PRE_LAST);
  assign w_lo_max[0]  = 1'b1;
  assign w_lo_zero[0] = 1'b1;

  // A digit steps only when every lower digit is at its terminal value.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam logic [3:0] c_MAX = (i == NDIG - 1) ? 4'(TOP_MOD - 1) : 4'd9;
    logic [3:0] w_d;
    logic [3:0] w_ld;

    assign w_d             = r_cnt[4*i +: 4];
    assign w_ld            = load_val[4*i +: 4];
    assign w_lo_max[i+1]   = w_lo_max[i] && (w_d == c_MAX);
    assign w_lo_zero[i+1]  = w_lo_zero[i] && (w_d == 4'd0);
    assign w_load_val[4*i +: 4] = (w_ld > c_MAX) ? c_MAX : w_ld;
    assign w_step_val[4*i +: 4] =
      up ? (w_lo_max[i]  ? ((w_d == c_MAX) ? 4'd0  : w_d + 4'd1) : w_d)
         : (w_lo_zero[i] ? ((w_d == 4'd0)  ? c_MAX : w_d - 4'd1) : w_d);
  end

  assign w_full = up ? w_lo_max[NDIG] : w_lo_zero[NDIG];

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_pre  <= '0;
      r_cnt  <= '0;
      r_wrap <= 1'b0;
    end else if (load) begin
      r_pre  <= '0;
      r_cnt  <= w_load_val;
      r_wrap <= 1'b0;
    end else begin
      if (en) begin
        r_pre <= (r_pre == c_PRE_LAST) ? '0 : r_pre + 1'b1;
      end
      if (w_tick) begin
        r_cnt <= w_step_val;
      end
      r_wrap <= w_tick && w_full;
    end
  end

  assign cnt  = r_cnt;
  assign tick = w_tick;
  assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: doc/bcd_cascade_counter.md
BCD_CASCADE_COUNTER -- requirements
Module: bcd_cascade_counter

Interface
REQ-001 SHALL have parameter NDIG, default 4, number of BCD digits (legal 1..8).
REQ-002 SHALL have parameter DIV, default 50000000, prescaler period in mclk cycles (legal >=1).
REQ-003 SHALL have parameter TOP_MOD, default 10, modulus of the most significant digit (legal 2..10, e.g. 6 for a 0..59 pair).
REQ-004 SHALL have port mclk  input  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en  input  1  count enable; 0 freezes prescaler and digits.
REQ-007 SHALL have port up  input  1  direction; 1 = increment, 0 = decrement.
REQ-008 SHALL have port load  input  1  synchronous parallel load strobe.
REQ-009 SHALL have port load_val  input  4*NDIG  packed BCD load value, digit 0 in [3:0].
REQ-010 SHALL have port cnt  output  4*NDIG  packed BCD count, digit 0 (least significant) in [3:0].
REQ-011 SHALL have port tick  output  1  prescaler terminal pulse.
REQ-012 SHALL have port wrap  output  1  one-cycle full-range wrap indicator.

Function
REQ-013 Prescaler SHALL count 0..DIV-1 on each mclk edge with en=1, returning to 0 after DIV-1; with en=0 it SHALL hold.
REQ-014 tick SHALL be combinational: tick = en AND prescaler==DIV-1 AND NOT reset; with DIV=1, tick = en AND NOT reset.
REQ-015 Digits SHALL update on the mclk edge at which tick=1 (latency 0 cycles from tick to cnt change); up SHALL be sampled on that edge only.
REQ-016 Digit max SHALL be 9 for digits 0..NDIG-2 and TOP_MOD-1 for digit NDIG-1.
REQ-017 Up count: digit 0 SHALL increment; digit i>0 SHALL increment only when all lower digits are at max; a digit at max that steps SHALL wrap to 0.
REQ-018 Down count: digit 0 SHALL decrement; digit i>0 SHALL decrement only when all lower digits are 0; a digit at 0 that steps SHALL wrap to its max.
REQ-019 Full-range wrap (all-max -> all-zero counting up, all-zero -> all-max counting down) SHALL set registered wrap=1 for exactly the one cycle in which cnt shows the wrapped value; otherwise wrap=0.
REQ-020 Priority SHALL be reset > load > count.
REQ-021 load=1 SHALL, on that edge and regardless of en, set cnt to load_val, clear the prescaler to 0, and force wrap=0; no count step occurs on that edge even if tick=1.
REQ-022 A loaded digit exceeding its max (>9 for lower digits, >TOP_MOD-1 for the top digit) SHALL be replaced by that digit's max.
REQ-023 cnt SHALL never hold a non-BCD or out-of-range digit.
REQ-024 Changing up between ticks SHALL affect only the next tick; changing en mid-period SHALL preserve the prescaler phase.

Reset
REQ-025 reset=1 on an mclk edge SHALL set cnt=0, prescaler=0, wrap=0, overriding load and en.
REQ-026 While reset=1, tick SHALL be 0; reset asserted mid-period SHALL discard the partial prescaler count.

Verification (NDIG=4, TOP_MOD=6 unless stated)
REQ-027 DIV=1, load 0x5999, up=1, en=1, one cycle -> cnt=0x0000, wrap=1 for one cycle, then cnt=0x0001, wrap=0.
REQ-028 DIV=1, load 0x0000, up=0, one cycle -> cnt=0x5999, wrap=1; next cycle -> 0x5998, wrap=0.
REQ-029 DIV=1, load 0x0099, up=1, one cycle -> 0x0100; then up=0, one cycle -> 0x0099, wrap=0 throughout.
REQ-030 load_val=0xA7F3 -> cnt=0x5793 next cycle, same result with en=0; TOP_MOD=10 -> 0x9793.
REQ-031 DIV=4, en=1 from cnt=0: tick on cycles 4, 8, 12, cnt=1, 2, 3; en=0 for 5 cycles after cycle 6 -> cnt holds 1, next tick 2 cycles after en returns.
REQ-032 DIV=4, reset and load both high mid-period at cnt=0x0042 -> cnt=0x0000, tick=0, next tick 4 enabled cycles after reset deasserts.
